adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the operand width, fixed by the shared adder.
REQ-003 SHALL have parameter OUT_DEPTH, default 2, meaning the result FIFO depth (>=2).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid_i, input, NUM_REQ, per-requester operand-pair valid.
REQ-007 SHALL have port req_ready_o, output, NUM_REQ, per-requester accept; at most one bit high.
REQ-008 SHALL have port req_a_i, input, NUM_REQ*DATA_W, packed first operands; requester i at [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_b_i, input, NUM_REQ*DATA_W, packed second operands, same packing.
REQ-010 SHALL have port rsp_valid_o, output, 1, result available.
REQ-011 SHALL have port rsp_ready_i, input, 1, downstream accepts result.
REQ-012 SHALL have port rsp_id_o, output, clog2(NUM_REQ), index of the requester owning the result.
REQ-013 SHALL have port rsp_sum_o, output, DATA_W+1, unsigned sum including carry.
REQ-014 SHALL have port busy_o, output, 1, high when any operation is in flight or buffered.

Function
REQ-015 SHALL accept requester i in a cycle iff req_valid_i[i] and req_ready_o[i] are both high.
REQ-016 SHALL arbitrate round-robin: priority starts at last-accepted index + 1, wrapping NUM_REQ-1 -> 0.
REQ-017 SHALL update the round-robin pointer only on an accept; an ungranted requester SHALL keep its priority position.
REQ-018 SHALL drive req_ready_o[i] high only for the arbitration winner and only when issue is permitted.
REQ-019 SHALL permit issue when credit count > 0, or when credit count == 0 and a result pop (rsp_valid_o & rsp_ready_i) occurs in the same cycle.
REQ-020 SHALL keep a credit counter: decrement on accept, increment on pop, unchanged when both occur together; range 0..OUT_DEPTH.
REQ-021 SHALL present the accepted operands to the shared adder in the accept cycle T; the adder registers the sum at the end of T.
REQ-022 SHALL track the in-flight tag (valid bit + requester id) in a register alongside the adder stage.
REQ-023 SHALL write {id, sum} into the result FIFO at the end of T+1, giving rsp_valid_o high in T+2 (2-cycle latency).
REQ-024 SHALL sustain one accept per cycle while rsp_ready_i is held high.
REQ-025 SHALL return results in accept order (FIFO), never reordered.
REQ-026 SHALL hold rsp_valid_o, rsp_id_o, rsp_sum_o stable while rsp_valid_o & !rsp_ready_i.
REQ-027 SHALL never overflow the result FIFO; credit accounting (REQ-019/020) guarantees this.
REQ-028 SHALL compute 0xFFFF + 0xFFFF = 0x1FFFE with no truncation.
REQ-029 SHALL drive busy_o = in-flight valid OR FIFO non-empty.

Reset
REQ-030 SHALL, with rst_i high at a posedge, set credits = OUT_DEPTH, RR pointer = NUM_REQ-1 (requester 0 highest priority), in-flight valid = 0, and FIFO empty.
REQ-031 SHALL hold req_ready_o = 0, rsp_valid_o = 0, rsp_id_o = 0, rsp_sum_o = 0, busy_o = 0 while rst_i is asserted and in the cycle after.
REQ-032 SHALL discard in-flight and buffered results on reset mid-operation; no rsp_valid_o SHALL appear for pre-reset accepts.

Structure
REQ-033 SHALL place DATA_W, the default NUM_REQ and the result-entry width constant in the shared package adder_pkg.
REQ-034 SHALL instantiate the existing adder module as the sole arithmetic sub-module, with clk_i and 16-bit operands; the adder has no reset and its output SHALL be qualified only by the in-flight valid bit.
REQ-035 SHALL implement the result FIFO inline; a separate FIFO sub-module is not required.

Verification
REQ-036 Single request: req0 a=0x0003, b=0x0004 -> ready0 in T, rsp_valid in T+2 with id=0, sum=0x00007.
REQ-037 Carry: req2 a=0xFFFF, b=0xFFFF -> id=2, sum=0x1FFFE.
REQ-038 All 4 requesters valid continuously with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one rsp per cycle after 2-cycle fill.
REQ-039 Backpressure: rsp_ready=0 with req0 streaming -> exactly 2 accepts, then req_ready_o=0; on rsp_ready=1, accepts resume the same cycle as the first pop; no loss or reorder.
REQ-040 Reset with 1 in flight and 1 buffered -> rsp_valid_o=0, busy_o=0 afterwards; the next request gets the full 2-cycle latency and credits are back at 2.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the arbitrated adder block.
package adder_pkg;
  // Operand width of the shared adder.
  localparam int DATA_W      = 16;
  // Default number of requesters.
  localparam int NUM_REQ_DEF = 4;
  // Width of the sum field of a result entry (carry included).
  localparam int RES_W       = DATA_W + 1;
  // Width of a full result entry {id, sum} at the default requester count.
  localparam int ENTRY_W     = $clog2(NUM_REQ_DEF) + RES_W;
endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared registered adder: one-cycle latency, no reset.
// The output is meaningful only when the caller's in-flight tag says so.
module adder_arbiter_adder
  import adder_pkg::*;
#(
  parameter int W = adder_pkg::DATA_W
) (
  input  logic         clk_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);
  logic [W:0] sum_d, sum_q;

  // Full-width unsigned sum, carry kept in the top bit.
  always_comb begin
    sum_d = {1'b0, a_i} + {1'b0, b_i};
  end

  // Result register; qualified downstream by the in-flight valid bit.
  always_ff @(posedge clk_i) begin
    sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Credits bound in-flight plus buffered results to OUT_DEPTH, so the result
// FIFO can never overflow; issue is also allowed on a same-cycle pop.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = adder_pkg::DATA_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [DATA_W:0]            rsp_sum_o,
  output logic                       busy_o
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic              rst_d_q, rst_d_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic              inflt_vld_q, inflt_vld_d;
  logic [ID_W-1:0]   inflt_id_q, inflt_id_d;
  logic [ID_W-1:0]   fifo_id_q  [OUT_DEPTH];
  logic [ID_W-1:0]   fifo_id_d  [OUT_DEPTH];
  logic [DATA_W:0]   fifo_sum_q [OUT_DEPTH];
  logic [DATA_W:0]   fifo_sum_d [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ID_W-1:0]   win, idx;
  logic              any_vld, fifo_vld, pop, push, issue_ok, accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   add_sum;

  // Round-robin pick: scan from ptr+NUM_REQ down to ptr+1 so ptr+1 wins last.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid_i[idx]) begin
        win     = idx;
        any_vld = 1'b1;
      end
    end
  end

  assign fifo_vld = (count_q != '0);
  assign pop      = fifo_vld & rsp_ready_i & ~rst_i;
  assign push     = inflt_vld_q;
  assign issue_ok = (credit_q != '0) | pop;
  // Accepts are held off during reset and the cycle after it.
  assign accept   = any_vld & issue_ok & ~rst_i & ~rst_d_q;

  // One-hot ready to the winner only when an accept happens.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[win] = 1'b1;
  end

  assign op_a = req_a_i[win*DATA_W +: DATA_W];
  assign op_b = req_b_i[win*DATA_W +: DATA_W];

  adder_arbiter_adder #(.W(DATA_W)) u_add (
    .clk_i (clk_i),
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (add_sum)
  );

  // Next state: credits, RR pointer, in-flight tag and inline FIFO.
  always_comb begin
    rst_d_d     = rst_i;
    credit_d    = credit_q;
    ptr_d       = ptr_q;
    inflt_vld_d = accept;
    inflt_id_d  = accept ? win : inflt_id_q;
    fifo_id_d   = fifo_id_q;
    fifo_sum_d  = fifo_sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (accept && !pop)      credit_d = credit_q - CNT_W'(1);
    else if (pop && !accept) credit_d = credit_q + CNT_W'(1);

    if (accept) ptr_d = win;

    if (push) begin
      fifo_id_d[wr_ptr_q]  = inflt_id_q;
      fifo_sum_d[wr_ptr_q] = add_sum;
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // State registers with synchronous reset; reset drops all pending results.
  always_ff @(posedge clk_i) begin
    rst_d_q <= rst_d_d;
    if (rst_i) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      credit_q    <= CNT_W'(OUT_DEPTH);
      inflt_vld_q <= 1'b0;
      inflt_id_q  <= '0;
      fifo_id_q   <= '{default: '0};
      fifo_sum_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
      inflt_vld_q <= inflt_vld_d;
      inflt_id_q  <= inflt_id_d;
      fifo_id_q   <= fifo_id_d;
      fifo_sum_q  <= fifo_sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Outputs forced to zero while reset is asserted; payload zero when idle.
  assign rsp_valid_o = fifo_vld & ~rst_i;
  assign rsp_id_o    = rsp_valid_o ? fifo_id_q[rd_ptr_q]  : '0;
  assign rsp_sum_o   = rsp_valid_o ? fifo_sum_q[rd_ptr_q] : '0;
  assign busy_o      = ~rst_i & (inflt_vld_q | fifo_vld);
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: vector table for single requests plus hand-written
// sequences for round-robin, backpressure and mid-operation reset.
module tb_adder_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [DW:0]       rsp_sum;

  int errors = 0;
  int checks = 0;

  adder_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OUT_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [2:0]  gseq   [5] = '{0, 1, 2, 3, 0};
  logic        bp_rdy [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
  logic        bp_vld [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [16:0] bp_sum [9] = '{0, 0, 'h100, 'h100, 'h100, 'h101, 'h102, 'h103, 0};
  int n;

  initial begin
    vt[0] = '{0, 16'h0003, 16'h0004, 17'h00007};
    vt[1] = '{2, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vt[2] = '{1, 16'h1234, 16'h4321, 17'h05555};
    vt[3] = '{3, 16'h8000, 16'h8000, 17'h10000};
    vt[4] = '{0, 16'h0000, 16'h0000, 17'h00000};
    vt[5] = '{1, 16'h00FF, 16'h0001, 17'h00100};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick();
    // Still in reset with a request pending: everything must read zero.
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    tick();
    rst = 1'b0;
    // Cycle after reset: no accept yet.
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 0);
    req_valid = '0;
    tick();

    // Table-driven single requests, 2-cycle latency each.
    for (int v = 0; v < 6; v++) begin
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      req_a[vt[v].id*DW +: DW] = vt[v].a;
      req_b[vt[v].id*DW +: DW] = vt[v].b;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1) << vt[v].id);
      chk($sformatf("vec%0d_rsp_idle", v), 32'(rsp_valid), 0);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_t1_valid", v), 32'(rsp_valid), 0);
      chk($sformatf("vec%0d_t1_busy", v), 32'(busy), 1);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 1);
      chk($sformatf("vec%0d_id", v), 32'(rsp_id), vt[v].id);
      chk($sformatf("vec%0d_sum", v), 32'(rsp_sum), 32'(vt[v].sum));
      tick();
    end

    // Round-robin with all requesters valid and no backpressure.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = 16'(i + 1);
      req_b[i*DW +: DW] = 16'h0010;
    end
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 5) ? 4'hF : 4'h0;
      @(negedge clk);
      chk($sformatf("rr%0d_ready", c), 32'(req_ready), (c < 5) ? (32'(1) << gseq[c]) : 0);
      if (c >= 2) begin
        chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 1);
        chk($sformatf("rr%0d_id", c), 32'(rsp_id), 32'(gseq[c-2]));
        chk($sformatf("rr%0d_sum", c), 32'(rsp_sum), 32'(gseq[c-2]) + 32'h11);
      end else begin
        chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 0);
      end
      tick();
    end
    @(negedge clk);
    chk("rr_idle_busy", 32'(busy), 0);
    tick();

    // Backpressure: two accepts fill the credits, resume on first pop.
    do_reset();
    rsp_ready = 1'b0;
    req_b = '0;
    n = 0;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b0001 : 4'b0000;
      req_a[0 +: DW] = 16'(32'h100 + n);
      rsp_ready = (c >= 4);
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'(bp_rdy[c]));
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'(bp_vld[c]));
      if (bp_vld[c]) chk($sformatf("bp%0d_sum", c), 32'(rsp_sum), 32'(bp_sum[c]));
      if (req_ready[0]) n++;
      tick();
    end
    chk("bp_accepts", n, 4);

    // Reset with one result in flight and one buffered.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[0 +: DW] = 16'h0011;
    @(negedge clk);
    chk("mr_acc0", 32'(req_ready), 1);
    tick();
    req_a[0 +: DW] = 16'h0022;
    @(negedge clk);
    chk("mr_acc1", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    #1;
    chk("mr_pre_valid", 32'(rsp_valid), 1);
    chk("mr_pre_sum", 32'(rsp_sum), 32'h11);
    chk("mr_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_valid", 32'(rsp_valid), 0);
    chk("mr_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0001;
    req_a[0 +: DW] = 16'h0005;
    req_b[0 +: DW] = 16'h0006;
    @(negedge clk);
    chk("mr_post_ready", 32'(req_ready), 0);
    chk("mr_post_valid", 32'(rsp_valid), 0);
    chk("mr_post_busy", 32'(busy), 0);
    tick();
    @(negedge clk);
    chk("mr_acc_a", 32'(req_ready), 1);
    chk("mr_t0_valid", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    chk("mr_acc_b", 32'(req_ready), 1);
    chk("mr_t1_valid", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    chk("mr_credit_empty", 32'(req_ready), 0);
    chk("mr_t2_valid", 32'(rsp_valid), 1);
    chk("mr_t2_id", 32'(rsp_id), 0);
    chk("mr_t2_sum", 32'(rsp_sum), 32'h0B);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("mr_hold_valid", 32'(rsp_valid), 1);
    chk("mr_hold_sum", 32'(rsp_sum), 32'h0B);
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("mr_drain_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
